// File: rtl/xpb_table_gen.sv
// Run-time generator for a reduction lookup table: streams xpb[k] = k*B mod M
// for k = 0 .. 2^DIGIT_BITS-1 into the table RAM through a ready/valid write port.
module xpb_table_gen #(
    parameter int unsigned WIDTH      = 1024,
    parameter int unsigned DIGIT_BITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      base,
    input  logic [WIDTH-1:0]      modulus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  wr_en,
    input  logic                  wr_ready,
    output logic [DIGIT_BITS-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        GEN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sum_red;
    logic [WIDTH-1:0] acc_next;
    logic             bad_operands;
    logic             accept;
    logic             last_beat;

    // acc < M and B < M, so one conditional subtract keeps the sum reduced.
    always_comb begin
        bad_operands = (m_q == '0) || (b_q >= m_q);
        accept       = (state == GEN) && wr_ready;
        last_beat    = accept && (wr_addr == '1);
        sum          = {1'b0, acc} + {1'b0, b_q};
        sum_red      = (sum >= {1'b0, m_q}) ? (sum - {1'b0, m_q}) : sum;
        acc_next     = sum_red[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                busy       = 1'b1;
                state_next = bad_operands ? DONE : GEN;
            end
            GEN: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_q     <= '0;
            m_q     <= '0;
            acc     <= '0;
            error   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        b_q   <= base;
                        m_q   <= modulus;
                        error <= 1'b0;
                    end
                end
                CHECK: begin
                    if (bad_operands) begin
                        error <= 1'b1;
                    end else begin
                        acc     <= '0;
                        wr_addr <= '0;
                        wr_data <= '0;
                    end
                end
                GEN: begin
                    // The last accepted beat wraps wr_addr back to 0.
                    if (accept) begin
                        acc     <= acc_next;
                        wr_data <= acc_next;
                        wr_addr <= wr_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed bench for xpb_table_gen: a 16-bit instance for cycle-exact checks and a
// 1024-bit instance compared against a direct k*B mod M reference.
module tb_xpb_table_gen;

    logic          clk;
    logic          reset;

    logic          start16;
    logic [15:0]   base16;
    logic [15:0]   mod16;
    logic          busy16;
    logic          done16;
    logic          error16;
    logic          wr_en16;
    logic          wr_ready16;
    logic [4:0]    wr_addr16;
    logic [15:0]   wr_data16;

    logic          startw;
    logic [1023:0] basew;
    logic [1023:0] modw;
    logic          busyw;
    logic          donew;
    logic          errorw;
    logic          wr_enw;
    logic          wr_readyw;
    logic [4:0]    wr_addrw;
    logic [1023:0] wr_dataw;

    int n_cmp;
    int n_bad;
    logic [15:0] got16 [32];

    xpb_table_gen #(.WIDTH(16), .DIGIT_BITS(5)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .base(base16), .modulus(mod16),
        .busy(busy16), .done(done16), .error(error16), .wr_en(wr_en16),
        .wr_ready(wr_ready16), .wr_addr(wr_addr16), .wr_data(wr_data16)
    );

    xpb_table_gen #(.WIDTH(1024), .DIGIT_BITS(5)) dutw (
        .clk(clk), .reset(reset), .start(startw), .base(basew), .modulus(modw),
        .busy(busyw), .done(donew), .error(errorw), .wr_en(wr_enw),
        .wr_ready(wr_readyw), .wr_addr(wr_addrw), .wr_data(wr_dataw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts one 16-bit run in the current cycle (cycle 0) and follows it to done.
    task automatic run16(input string tag, input logic [15:0] b, input logic [15:0] m,
                         input int stall_at, input int stall_n, input bit exp_err,
                         input int exp_done, input bit poke_start);
        int cyc;
        int writes;
        int done_cyc;
        int stalls;
        logic [31:0] prod;
        start16    = 1'b1;
        base16     = b;
        mod16      = m;
        wr_ready16 = 1'b1;
        @(posedge clk); #1;
        start16  = 1'b0;
        cyc      = 1;
        writes   = 0;
        done_cyc = -1;
        stalls   = 0;
        while (cyc < 200 && done_cyc < 0) begin
            if (stall_at >= 0 && wr_en16 && wr_addr16 == 5'(stall_at) && stalls < stall_n) begin
                wr_ready16 = 1'b0;
                stalls++;
            end else begin
                wr_ready16 = 1'b1;
            end
            if (poke_start && (cyc == 10 || done16)) begin
                start16 = 1'b1;
                base16  = 16'h0001;
                mod16   = 16'h0000;
            end
            #1;
            check($sformatf("%s busy c%0d", tag, cyc), 64'(busy16), 64'd1);
            if (cyc == 1) check($sformatf("%s err_clr", tag), 64'(error16), 64'd0);
            if (cyc == 2) check($sformatf("%s wr_en c2", tag), 64'(wr_en16), 64'(!exp_err));
            if (wr_en16) begin
                prod = 32'(wr_addr16) * 32'(b);
                check($sformatf("%s addr c%0d", tag, cyc), 64'(wr_addr16), 64'(writes));
                check($sformatf("%s data k%0d", tag, wr_addr16), 64'(wr_data16), 64'(prod % 32'(m)));
                if (wr_ready16) begin
                    got16[wr_addr16] = wr_data16;
                    writes++;
                end
            end
            if (done16) begin
                done_cyc = cyc;
                check($sformatf("%s error", tag), 64'(error16), 64'(exp_err));
            end
            @(posedge clk); #1;
            start16 = 1'b0;
            cyc++;
        end
        check($sformatf("%s done_cycle", tag), 64'(done_cyc), 64'(exp_done));
        check($sformatf("%s writes", tag), 64'(writes), exp_err ? 64'd0 : 64'd32);
        check($sformatf("%s idle_busy", tag), 64'(busy16), 64'd0);
        check($sformatf("%s idle_error", tag), 64'(error16), 64'(exp_err));
    endtask

    task automatic run_wide(input logic [1023:0] b, input logic [1023:0] m);
        int cyc;
        int done_cyc;
        logic [1028:0] prod;
        logic [1028:0] expv;
        logic [1023:0] d;
        startw    = 1'b1;
        basew     = b;
        modw      = m;
        wr_readyw = 1'b1;
        @(posedge clk); #1;
        startw   = 1'b0;
        cyc      = 1;
        done_cyc = -1;
        while (cyc < 200 && done_cyc < 0) begin
            if (wr_enw) begin
                prod = 1029'(wr_addrw) * {5'b0, b};
                expv = prod % {5'b0, m};
                d    = wr_dataw;
                check($sformatf("wide addr c%0d", cyc), 64'(wr_addrw), 64'(cyc - 2));
                for (int j = 0; j < 16; j++) begin
                    check($sformatf("wide k%0d w%0d", wr_addrw, j), d[j*64 +: 64], expv[j*64 +: 64]);
                end
            end
            if (donew) begin
                done_cyc = cyc;
                check("wide error", 64'(errorw), 64'd0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("wide done_cycle", 64'(done_cyc), 64'd34);
    endtask

    initial begin
        logic [1023:0] rb;
        logic [1023:0] rm;
        int guard;
        bit saw_done;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        start16 = 1'b0; base16 = '0; mod16 = '0; wr_ready16 = 1'b1;
        startw  = 1'b0; basew  = '0; modw  = '0; wr_readyw  = 1'b1;
        #12;
        check("rst busy", 64'(busy16), 64'd0);
        check("rst done", 64'(done16), 64'd0);
        check("rst error", 64'(error16), 64'd0);
        check("rst wr_en", 64'(wr_en16), 64'd0);
        check("rst wr_addr", 64'(wr_addr16), 64'd0);
        check("rst wr_data", 64'(wr_data16), 64'd0);
        check("rst wide wr_en", 64'(wr_enw), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        run16("basic", 16'h1234, 16'hFFF1, -1, 0, 1'b0, 34, 1'b0);
        check("basic k0", 64'(got16[0]), 64'h0000);
        check("basic k1", 64'(got16[1]), 64'h1234);
        check("basic k15", 64'(got16[15]), 64'h111B);
        check("basic k31", 64'(got16[31]), 64'h346A);

        run16("wrap", 16'hFFF0, 16'hFFF1, -1, 0, 1'b0, 34, 1'b0);
        check("wrap k1", 64'(got16[1]), 64'hFFF0);
        check("wrap k2", 64'(got16[2]), 64'hFFEF);
        check("wrap k31", 64'(got16[31]), 64'hFFD2);

        run16("err_bm", 16'hFFF1, 16'hFFF1, -1, 0, 1'b1, 2, 1'b0);
        run16("err_m0", 16'h0000, 16'h0000, -1, 0, 1'b1, 2, 1'b0);
        run16("bzero", 16'h0000, 16'hFFF1, -1, 0, 1'b0, 34, 1'b0);
        run16("stall", 16'h1234, 16'hFFF1, 5, 3, 1'b0, 37, 1'b0);
        check("stall k5", 64'(got16[5]), 64'h5B04);
        run16("poke", 16'h1234, 16'hFFF1, -1, 0, 1'b0, 34, 1'b1);
        check("poke k31", 64'(got16[31]), 64'h346A);

        start16 = 1'b1; base16 = 16'h1234; mod16 = 16'hFFF1; wr_ready16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        guard = 0;
        while (!(wr_en16 && wr_addr16 == 5'd12) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("rstmid reached k12", 64'(wr_addr16), 64'd12);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid wr_en", 64'(wr_en16), 64'd0);
        check("rstmid busy", 64'(busy16), 64'd0);
        check("rstmid done", 64'(done16), 64'd0);
        check("rstmid wr_addr", 64'(wr_addr16), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done16 || busy16) saw_done = 1'b1;
        end
        check("rstmid quiet", 64'(saw_done), 64'd0);
        run16("after_rst", 16'h1234, 16'hFFF1, -1, 0, 1'b0, 34, 1'b0);

        for (int i = 0; i < 32; i++) begin
            rb[i*32 +: 32] = $urandom;
            rm[i*32 +: 32] = $urandom;
        end
        rm[1023] = 1'b1;
        rb[1023] = 1'b0;
        run_wide(rb, rm);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
